// File: rtl/wbuf_pkg.sv
// Shared types and helpers for the write-through store merge buffer.
package wbuf_pkg;

  localparam int unsigned WBUF_DEPTH  = 8;
  localparam int unsigned WBUF_ADDR_W = 64;
  localparam int unsigned WBUF_DATA_W = 64;
  localparam int unsigned WBUF_BE_W   = WBUF_DATA_W / 8;
  localparam int unsigned WBUF_OFF_W  = $clog2(WBUF_BE_W);
  localparam int unsigned WBUF_TID_W  = 2;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    PEND = 2'd1,
    INFL = 2'd2
  } wbuf_state_e;

  typedef struct packed {
    logic [WBUF_ADDR_W-1:0] addr;
    logic [WBUF_DATA_W-1:0] data;
    logic [WBUF_BE_W-1:0]   be;
    logic                   nc;
    logic [WBUF_TID_W-1:0]  tid;
    wbuf_state_e            state;
  } wbuf_entry_t;

  // Clears the byte-offset bits so doubleword addresses compare directly.
  function automatic logic [WBUF_ADDR_W-1:0] dword_addr(input logic [WBUF_ADDR_W-1:0] a);
    return {a[WBUF_ADDR_W-1:WBUF_OFF_W], WBUF_OFF_W'(0)};
  endfunction

endpackage

// File: rtl/wbuf_tid_alloc.sv
// Free-bitmap transaction ID allocator: lowest-free grant, same-cycle alloc and release.
module wbuf_tid_alloc #(
  parameter int unsigned TID_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             alloc_i,
  input  logic             release_i,
  input  logic [TID_W-1:0] release_tid_i,
  output logic [TID_W-1:0] gnt_tid_c_o,
  output logic             any_free_c_o
);

  localparam int unsigned NUM_TID = 1 << TID_W;

  logic [NUM_TID-1:0] busy_q, busy_d;

  always_comb begin : grant
    gnt_tid_c_o  = '0;
    any_free_c_o = 1'b0;
    for (int i = int'(NUM_TID) - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        gnt_tid_c_o  = TID_W'(i);
        any_free_c_o = 1'b1;
      end
    end
  end

  // Releasing an idle ID leaves it idle, so stray acks are harmless.
  always_comb begin : next_busy
    busy_d = busy_q;
    if (release_i) busy_d[release_tid_i] = 1'b0;
    if (alloc_i && any_free_c_o) busy_d[gnt_tid_c_o] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  ack_known_tid : assert property (@(posedge clk_i) disable iff (rst_i)
                                   release_i |-> busy_q[release_tid_i])
    else $warning("wbuf_tid_alloc: ack for unallocated tid %0d", release_tid_i);

endmodule

// File: rtl/wt_store_merge_buffer.sv
// Merging store write buffer between the store unit and the memory adapter.
// Optional WBUF_MERGE_STATS_EN adds saturating allocation/merge counters.
module wt_store_merge_buffer
  import wbuf_pkg::*;
#(
  parameter int unsigned DEPTH = WBUF_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [WBUF_ADDR_W-1:0] req_addr_i,
  input  logic [WBUF_DATA_W-1:0] req_data_i,
  input  logic [WBUF_BE_W-1:0]   req_be_i,
  input  logic                   req_nc_i,
  output logic                   mem_valid_o,
  input  logic                   mem_ready_i,
  output logic [WBUF_ADDR_W-1:0] mem_addr_o,
  output logic [WBUF_DATA_W-1:0] mem_data_o,
  output logic [WBUF_BE_W-1:0]   mem_be_o,
  output logic                   mem_nc_o,
  output logic [WBUF_TID_W-1:0]  mem_tid_o,
  input  logic                   mem_ack_valid_i,
  input  logic [WBUF_TID_W-1:0]  mem_ack_tid_i,
  input  logic [WBUF_ADDR_W-1:0] hzd_addr_i,
  output logic                   hzd_o,
`ifdef WBUF_MERGE_STATS_EN
  output logic [31:0]            stat_alloc_o,
  output logic [31:0]            stat_merge_o,
`endif
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int unsigned ADDR_W = WBUF_ADDR_W;
  localparam int unsigned BE_W   = WBUF_BE_W;
  localparam int unsigned TID_W  = WBUF_TID_W;
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned PTR_W  = IDX_W + 1;

  wbuf_entry_t      entries_q [DEPTH];
  wbuf_entry_t      entries_d [DEPTH];
  logic [IDX_W-1:0] fifo_q    [DEPTH];
  logic [IDX_W-1:0] fifo_d    [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic             empty_q, empty_d, full_q, full_d;

  logic [IDX_W-1:0]  head_idx, hit_idx, alloc_idx;
  logic              fifo_nonempty, merge_hit, req_fire, issue_fire;
  logic              tid_any_free;
  logic [TID_W-1:0]  tid_gnt;
  logic [ADDR_W-1:0] req_dw, hzd_dw;

  wbuf_tid_alloc #(.TID_W(TID_W)) u_tid_alloc (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .alloc_i       (issue_fire),
    .release_i     (mem_ack_valid_i),
    .release_tid_i (mem_ack_tid_i),
    .gnt_tid_c_o   (tid_gnt),
    .any_free_c_o  (tid_any_free)
  );

  assign req_dw        = dword_addr(req_addr_i);
  assign hzd_dw        = dword_addr(hzd_addr_i);
  assign head_idx      = fifo_q[rd_ptr_q[IDX_W-1:0]];
  assign fifo_nonempty = (rd_ptr_q != wr_ptr_q);

  assign mem_valid_o = fifo_nonempty && (entries_q[head_idx].state == PEND) && tid_any_free;
  assign mem_addr_o  = entries_q[head_idx].addr;
  assign mem_data_o  = entries_q[head_idx].data;
  assign mem_be_o    = entries_q[head_idx].be;
  assign mem_nc_o    = entries_q[head_idx].nc;
  assign mem_tid_o   = tid_gnt;

  assign req_ready_o = merge_hit || !full_q;
  assign req_fire    = req_valid_i && req_ready_o;
  assign issue_fire  = mem_valid_o && mem_ready_i;
  assign empty_o     = empty_q;
  assign full_o      = full_q;

  // The presented head is locked so the issue payload stays stable until accepted.
  always_comb begin : search
    merge_hit = 1'b0;
    hit_idx   = '0;
    alloc_idx = '0;
    hzd_o     = 1'b0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (entries_q[i].state == FREE) alloc_idx = IDX_W'(i);
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!req_nc_i && (entries_q[i].state == PEND) && !entries_q[i].nc &&
          (entries_q[i].addr == req_dw) && !(mem_valid_o && (head_idx == IDX_W'(i)))) begin
        merge_hit = 1'b1;
        hit_idx   = IDX_W'(i);
      end
      if ((entries_q[i].state != FREE) && (entries_q[i].addr == hzd_dw)) hzd_o = 1'b1;
    end
  end

  always_comb begin : next_state
    entries_d = entries_q;
    fifo_d    = fifo_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    empty_d   = 1'b1;
    full_d    = 1'b1;

    for (int i = 0; i < int'(DEPTH); i++) begin
      if (mem_ack_valid_i && (entries_q[i].state == INFL) && (entries_q[i].tid == mem_ack_tid_i))
        entries_d[i].state = FREE;
    end

    if (issue_fire) begin
      entries_d[head_idx].state = INFL;
      entries_d[head_idx].tid   = tid_gnt;
      rd_ptr_d                  = rd_ptr_q + PTR_W'(1);
    end

    if (req_fire) begin
      if (merge_hit) begin
        for (int b = 0; b < int'(BE_W); b++) begin
          if (req_be_i[b]) entries_d[hit_idx].data[8*b +: 8] = req_data_i[8*b +: 8];
        end
        entries_d[hit_idx].be = entries_q[hit_idx].be | req_be_i;
      end else begin
        entries_d[alloc_idx] = '{addr: req_dw, data: req_data_i, be: req_be_i,
                                 nc: req_nc_i, tid: '0, state: PEND};
        fifo_d[wr_ptr_q[IDX_W-1:0]] = alloc_idx;
        wr_ptr_d                    = wr_ptr_q + PTR_W'(1);
      end
    end

    for (int i = 0; i < int'(DEPTH); i++) begin
      if (entries_d[i].state != FREE) empty_d = 1'b0;
      else                            full_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_q[i] <= '0;
        fifo_q[i]    <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      entries_q <= entries_d;
      fifo_q    <= fifo_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
    end
  end

`ifdef WBUF_MERGE_STATS_EN
  logic [31:0] stat_alloc_q, stat_merge_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_alloc_q <= '0;
      stat_merge_q <= '0;
    end else begin
      if (req_fire && !merge_hit && (stat_alloc_q != '1)) stat_alloc_q <= stat_alloc_q + 32'd1;
      if (req_fire &&  merge_hit && (stat_merge_q != '1)) stat_merge_q <= stat_merge_q + 32'd1;
    end
  end

  assign stat_alloc_o = stat_alloc_q;
  assign stat_merge_o = stat_merge_q;
`endif

endmodule

// File: tb/tb_wt_store_merge_buffer.sv
// Scoreboard bench for wt_store_merge_buffer against a queue-based store-buffer model.
module tb_wt_store_merge_buffer;

  localparam int DEPTH = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_nc_i;
  logic [63:0] req_addr_i, req_data_i;
  logic [7:0]  req_be_i;
  logic        mem_valid_o, mem_ready_i, mem_nc_o;
  logic [63:0] mem_addr_o, mem_data_o;
  logic [7:0]  mem_be_o;
  logic [1:0]  mem_tid_o, mem_ack_tid_i;
  logic        mem_ack_valid_i;
  logic [63:0] hzd_addr_i;
  logic        hzd_o, empty_o, full_o;
`ifdef WBUF_MERGE_STATS_EN
  logic [31:0] stat_alloc_o, stat_merge_o;
`endif

  wt_store_merge_buffer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_data_i(req_data_i), .req_be_i(req_be_i), .req_nc_i(req_nc_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_be_o(mem_be_o), .mem_nc_o(mem_nc_o), .mem_tid_o(mem_tid_o),
    .mem_ack_valid_i(mem_ack_valid_i), .mem_ack_tid_i(mem_ack_tid_i),
    .hzd_addr_i(hzd_addr_i), .hzd_o(hzd_o),
`ifdef WBUF_MERGE_STATS_EN
    .stat_alloc_o(stat_alloc_o), .stat_merge_o(stat_merge_o),
`endif
    .empty_o(empty_o), .full_o(full_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [63:0] addr; logic [63:0] data; logic [7:0] be; logic nc; } st_t;
  typedef struct { logic [63:0] addr; logic [63:0] data; logic [7:0] be; logic nc; logic [1:0] tid; } iss_t;

  // Model: in-order list of pending stores plus per-TID in-flight addresses.
  st_t         pend[$];
  iss_t        exp_q[$];
  bit          busy[4];
  logic [63:0] infl_addr[4];

  int  n_vec = 0, n_err = 0;
  bit  chk_en = 0;
  bit  p_valid, p_rdy, p_hzd, p_empty, p_full;
  bit  d_issue = 0, d_acc = 0, d_ack = 0;
  int  d_hit = -1;
  logic [1:0] d_gtid, d_atid;
  st_t d_st;
  iss_t mon_e;

  function automatic logic [63:0] dw(input logic [63:0] a);
    return a & ~64'h7;
  endfunction

  function automatic logic [63:0] bemask(input logic [7:0] be);
    logic [63:0] m = '0;
    for (int b = 0; b < 8; b++) if (be[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic int n_busy();
    int n = 0;
    for (int t = 0; t < 4; t++) if (busy[t]) n++;
    return n;
  endfunction

  function void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Called just after a rising edge: predicts this cycle and drives the DUT.
  task automatic drive(input bit v, input logic [63:0] a, input logic [63:0] d, input logic [7:0] be,
                       input bit nc, input bit rdy, input bit av, input logic [1:0] at,
                       input logic [63:0] ha);
    int occ = pend.size();
    int lo  = -1;
    for (int t = 0; t < 4; t++) begin
      if (busy[t]) occ++;
      else if (lo < 0) lo = t;
    end
    p_valid = (pend.size() > 0) && (lo >= 0);
    d_hit = -1;
    if (!nc) begin
      for (int i = p_valid ? 1 : 0; i < pend.size(); i++) begin
        if (!pend[i].nc && pend[i].addr == dw(a)) begin
          d_hit = i;
          break;
        end
      end
    end
    p_rdy   = (d_hit >= 0) || (occ < DEPTH);
    p_empty = (occ == 0);
    p_full  = (occ == DEPTH);
    p_hzd   = 1'b0;
    foreach (pend[i]) if (pend[i].addr == dw(ha)) p_hzd = 1'b1;
    for (int t = 0; t < 4; t++) if (busy[t] && infl_addr[t] == dw(ha)) p_hzd = 1'b1;
    d_issue = p_valid && rdy;
    d_gtid  = 2'(lo);
    if (d_issue)
      exp_q.push_back('{addr: pend[0].addr, data: pend[0].data, be: pend[0].be,
                        nc: pend[0].nc, tid: d_gtid});
    d_acc  = v && p_rdy;
    d_st   = '{addr: dw(a), data: d, be: be, nc: nc};
    d_ack  = av && busy[at];
    d_atid = at;
    req_valid_i = v; req_addr_i = a; req_data_i = d; req_be_i = be; req_nc_i = nc;
    mem_ready_i = rdy; mem_ack_valid_i = av; mem_ack_tid_i = at; hzd_addr_i = ha;
    chk_en = 1'b1;
  endtask

  task automatic tick();
    st_t e;
    @(posedge clk_i);
    if (d_ack) busy[d_atid] = 1'b0;
    if (d_acc && d_hit >= 0) begin
      e = pend[d_hit];
      for (int b = 0; b < 8; b++) if (d_st.be[b]) e.data[8*b +: 8] = d_st.data[8*b +: 8];
      e.be = e.be | d_st.be;
      pend[d_hit] = e;
    end
    if (d_issue) begin
      infl_addr[d_gtid] = pend[0].addr;
      busy[d_gtid] = 1'b1;
      void'(pend.pop_front());
    end
    if (d_acc && d_hit < 0) pend.push_back(d_st);
    #1;
  endtask

  task automatic idle(input bit rdy, input bit av, input logic [1:0] at, input logic [63:0] ha);
    drive(1'b0, 64'h0, 64'h0, 8'h0, 1'b0, rdy, av, at, ha);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    chk_en = 1'b0;
    d_issue = 0; d_acc = 0; d_ack = 0; d_hit = -1;
    req_valid_i = 0; req_addr_i = 0; req_data_i = 0; req_be_i = 0; req_nc_i = 0;
    mem_ready_i = 0; mem_ack_valid_i = 0; mem_ack_tid_i = 0; hzd_addr_i = 0;
    #1;
    check("rst_mem_valid", 64'(mem_valid_o), 64'd0);
    check("rst_empty", 64'(empty_o), 64'd1);
    check("rst_full", 64'(full_o), 64'd0);
    check("rst_req_ready", 64'(req_ready_o), 64'd1);
    check("rst_hzd", 64'(hzd_o), 64'd0);
    repeat (2) @(posedge clk_i);
    pend.delete();
    exp_q.delete();
    for (int t = 0; t < 4; t++) busy[t] = 1'b0;
    #1 rst_i = 1'b0;
  endtask

  task automatic drain();
    int cand[$];
    for (int k = 0; k < 300 && (pend.size() > 0 || n_busy() > 0); k++) begin
      cand.delete();
      for (int t = 0; t < 4; t++) if (busy[t]) cand.push_back(t);
      if (cand.size() > 0) idle(1'b1, 1'b1, 2'(cand[0]), 64'h0);
      else                 idle(1'b1, 1'b0, 2'd0, 64'h0);
      tick();
    end
    check("drain_left", 64'(pend.size() + n_busy()), 64'd0);
  endtask

  // Scoreboard monitor: every accepted issue must match the oldest expected one.
  always @(negedge clk_i) begin
    if (!rst_i && mem_valid_o && mem_ready_i) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL iss_unexpected: got issue addr 0x%0h, expected none at %0t", mem_addr_o, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("iss_addr", mem_addr_o, mon_e.addr);
        check("iss_be", 64'(mem_be_o), 64'(mon_e.be));
        check("iss_data", mem_data_o & bemask(mon_e.be), mon_e.data & bemask(mon_e.be));
        check("iss_nc", 64'(mem_nc_o), 64'(mon_e.nc));
        check("iss_tid", 64'(mem_tid_o), 64'(mon_e.tid));
      end
    end
  end

  always @(negedge clk_i) begin
    if (!rst_i && chk_en) begin
      check("req_ready", 64'(req_ready_o), 64'(p_rdy));
      check("mem_valid", 64'(mem_valid_o), 64'(p_valid));
      check("hzd", 64'(hzd_o), 64'(p_hzd));
      check("empty", 64'(empty_o), 64'(p_empty));
      check("full", 64'(full_o), 64'(p_full));
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int cand[$];
    bit av;
    logic [1:0] at;
    do_reset();

    // Merge behind the head: 0x10 and 0x14 combine into one doubleword.
    drive(1, 64'h8000_0100, 64'h0000_AAAA, 8'h03, 0, 0, 0, 0, 0); tick();
    drive(1, 64'h8000_0010, 64'h1122_3344, 8'h0F, 0, 0, 0, 0, 0); tick();
    drive(1, 64'h8000_0014, 64'h5566_7788_0000_0000, 8'hF0, 0, 0, 0, 0, 0); tick();
    idle(1, 0, 0, 0); tick();
    idle(1, 0, 0, 0); #1;
    check("dir_merge_addr", mem_addr_o, 64'h8000_0010);
    check("dir_merge_be", 64'(mem_be_o), 64'hFF);
    check("dir_merge_data", mem_data_o, 64'h5566_7788_1122_3344);
    check("dir_merge_tid", 64'(mem_tid_o), 64'd1);
    tick();
    idle(0, 0, 0, 64'h8000_0017); #1;
    check("dir_hzd_infl", 64'(hzd_o), 64'd1);
    tick();
    idle(0, 1, 2'd0, 64'h8000_0017); tick();
    idle(0, 1, 2'd1, 64'h8000_0017); tick();
    idle(0, 0, 0, 64'h8000_0017); #1;
    check("dir_hzd_clear", 64'(hzd_o), 64'd0);
    check("dir_empty", 64'(empty_o), 64'd1);
    tick();

    // Non-cacheable stores never merge.
    drive(1, 64'h8000_0010, 64'h1122_3344, 8'h0F, 1, 0, 0, 0, 0); tick();
    drive(1, 64'h8000_0014, 64'h5566_7788_0000_0000, 8'hF0, 1, 0, 0, 0, 0); tick();
    idle(1, 0, 0, 0); #1;
    check("dir_nc_tid0", 64'(mem_tid_o), 64'd0);
    check("dir_nc_be0", 64'(mem_be_o), 64'h0F);
    tick();
    idle(1, 0, 0, 0); #1;
    check("dir_nc_tid1", 64'(mem_tid_o), 64'd1);
    check("dir_nc_be1", 64'(mem_be_o), 64'hF0);
    tick();
    drain();

    // Fill all entries, then full-buffer merge and TID exhaustion.
    for (int k = 0; k < DEPTH; k++) begin
      drive(1, 64'h8000_1000 + 64'(8 * k), 64'(k), 8'h01, 0, 0, 0, 0, 0);
      tick();
    end
    drive(1, 64'h8000_2000, 64'h0, 8'h01, 0, 0, 0, 0, 0); #1;
    check("dir_full", 64'(full_o), 64'd1);
    check("dir_full_noready", 64'(req_ready_o), 64'd0);
    tick();
    drive(1, 64'h8000_1010, 64'hFF00, 8'h02, 0, 0, 0, 0, 0); #1;
    check("dir_full_merge_ready", 64'(req_ready_o), 64'd1);
    tick();
    repeat (4) begin idle(1, 0, 0, 0); tick(); end
    idle(1, 0, 0, 0); #1;
    check("dir_tid_exhausted", 64'(mem_valid_o), 64'd0);
    tick();
    idle(1, 1, 2'd2, 0); tick();
    idle(1, 0, 0, 0); #1;
    check("dir_tid2_valid", 64'(mem_valid_o), 64'd1);
    check("dir_tid2", 64'(mem_tid_o), 64'd2);
    tick();
    drain();

    // Reset with stores in flight; stale ack afterwards is ignored.
    for (int k = 0; k < 3; k++) begin
      drive(1, 64'h8000_3000 + 64'(8 * k), 64'(k), 8'hFF, 0, 0, 0, 0, 0);
      tick();
    end
    repeat (3) begin idle(1, 0, 0, 0); tick(); end
    do_reset();
    idle(0, 1, 2'd0, 0); tick();
    idle(0, 0, 0, 0); #1;
    check("dir_post_rst_empty", 64'(empty_o), 64'd1);
    check("dir_post_rst_valid", 64'(mem_valid_o), 64'd0);
    tick();

    // Randomized traffic over a small address pool to exercise merges and hazards.
    for (int c = 0; c < 1500; c++) begin
      cand.delete();
      for (int t = 0; t < 4; t++) if (busy[t]) cand.push_back(t);
      av = (cand.size() > 0) && ($urandom % 2 == 0);
      at = av ? 2'(cand[$urandom % cand.size()]) : 2'd0;
      drive($urandom % 3 != 0,
            64'h8000_0000 + 64'(($urandom % 12) * 8 + $urandom % 8),
            {$urandom, $urandom}, 8'($urandom % 256), $urandom % 5 == 0,
            $urandom % 3 != 0, av, at,
            64'h8000_0000 + 64'(($urandom % 16) * 8 + $urandom % 8));
      tick();
    end
    drain();
    idle(0, 0, 0, 0); tick();
    check("exp_q_left", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
